rx_audio_frame_unpack: RTL and testbench

Consumer-side decoder for the interleaved rx audio buffer stream, in the cpu_clk domain. Accepts the 16-bit words of one buffer frame in read order: per-sample, per-channel I/Q triplets, then the 48-bit ticks timestamp, then the buffer counter word. Reassembles 24-bit I/Q samples tagged with channel and sample index, latches the timestamp, and checks buffer-counter continuity to detect dropped or duplicated frames.

---
 rtl/rx_audio_frame_unpack_if.sv | 29 ++
 rtl/rx_audio_frame_unpack.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rx_audio_frame_unpack.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_audio_frame_unpack_if.sv
// Stream-side bundle for rx_audio_frame_unpack: 16-bit word input and
// reassembled I/Q sample output, each with a valid/ready handshake.
interface rx_audio_frame_unpack_if #(
  parameter int NCH_MAX = 8
);
  localparam int CHW = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;

  logic            in_valid;
  logic [15:0]     in_data;
  logic            in_ready;
  logic            samp_valid;
  logic            samp_ready;
  logic [CHW-1:0]  samp_ch;
  logic [15:0]     samp_idx;
  logic [23:0]     samp_i;
  logic [23:0]     samp_q;

  // Producer of words / consumer of samples
  modport master (
    output in_valid, in_data, samp_ready,
    input  in_ready, samp_valid, samp_ch, samp_idx, samp_i, samp_q
  );

  // The unpacker itself
  modport slave (
    input  in_valid, in_data, samp_ready,
    output in_ready, samp_valid, samp_ch, samp_idx, samp_i, samp_q
  );
endinterface

// File: rtl/rx_audio_frame_unpack.sv
// Decodes one interleaved rx audio buffer frame per pass: I/Q triplets per
// sample/channel, a 48-bit ticks timestamp, then a buffer counter word whose
// continuity is checked against the previous frame.
module rx_audio_frame_unpack #(
  parameter int NCH_MAX = 8
) (
  input  logic                      cpu_clk,
  input  logic                      reset,
  input  logic                      reset_bufs,
  input  logic [15:0]               nrx_samps,
  input  logic [3:0]                nrx_chans,
  rx_audio_frame_unpack_if.slave    s,
  output logic [47:0]               ticks,
  output logic                      ticks_valid,
  output logic [15:0]               buf_ctr,
  output logic                      frame_done,
  output logic                      seq_err,
  output logic                      seq_err_pulse
);

  localparam int CHW = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1;
  localparam logic [3:0] NCH_MAX4 = 4'(NCH_MAX);

  typedef enum logic [2:0] {
    S_W0, S_W1, S_W2, S_T0, S_T1, S_T2, S_CTR
  } state_t;

  state_t          r_state;
  state_t          w_cur_state;
  state_t          w_nxt_state;

  logic            r_first;
  logic [15:0]     r_nsamps;
  logic [CHW-1:0]  r_ch_last;
  logic [CHW-1:0]  r_ch;
  logic [15:0]     r_idx;

  logic [15:0]     r_w0;
  logic [15:0]     r_w1;
  logic [15:0]     r_t0;
  logic [15:0]     r_t1;

  logic            r_samp_valid;
  logic [CHW-1:0]  r_samp_ch;
  logic [15:0]     r_samp_idx;
  logic [23:0]     r_samp_i;
  logic [23:0]     r_samp_q;

  logic [47:0]     r_ticks;
  logic            r_ticks_valid;
  logic [15:0]     r_buf_ctr;
  logic            r_frame_done;
  logic            r_seq_err;
  logic            r_seq_err_pulse;
  logic            r_primed;

  logic [3:0]      w_nch_eff;
  logic [CHW-1:0]  w_ch_last_live;
  logic            w_last_samp;
  logic            w_ctr_gap;
  logic            w_in_ready;
  logic            w_acc;
  logic            w_ld_w0;
  logic            w_ld_w1;
  logic            w_ld_w2;
  logic            w_ld_t0;
  logic            w_ld_t1;
  logic            w_ld_t2;
  logic            w_ld_ctr;

  // Channel count as used by the frame: 0 means 1, clamped to NCH_MAX
  always_comb begin
    w_nch_eff = nrx_chans;
    if (nrx_chans == '0)
      w_nch_eff = 4'd1;
    else if (nrx_chans > NCH_MAX4)
      w_nch_eff = NCH_MAX4;
  end

  assign w_ch_last_live = CHW'(w_nch_eff - 4'd1);

  // While a frame start is pending, the word is decoded against the live
  // nrx_samps, which is the value captured by that same word.
  assign w_cur_state = r_first ? ((nrx_samps == '0) ? S_T0 : S_W0) : r_state;

  assign w_last_samp = (r_ch == r_ch_last) && (r_idx == r_nsamps - 16'd1);
  assign w_ctr_gap   = (s.in_data != r_buf_ctr + 16'd1);

  // State register
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset)
      r_state <= S_W0;
    else if (reset_bufs)
      r_state <= S_W0;
    else
      r_state <= w_nxt_state;
  end

  // Next-state decode; advances only on an accepted word
  always_comb begin
    w_nxt_state = w_cur_state;
    if (w_acc) begin
      case (w_cur_state)
        S_W0:    w_nxt_state = S_W1;
        S_W1:    w_nxt_state = S_W2;
        S_W2:    w_nxt_state = w_last_samp ? S_T0 : S_W0;
        S_T0:    w_nxt_state = S_T1;
        S_T1:    w_nxt_state = S_T2;
        S_T2:    w_nxt_state = S_CTR;
        S_CTR:   w_nxt_state = (nrx_samps == '0) ? S_T0 : S_W0;
        default: w_nxt_state = S_W0;
      endcase
    end
  end

  // Handshake and per-word load strobes
  always_comb begin
    w_in_ready = !r_samp_valid || s.samp_ready;
    w_acc      = s.in_valid && w_in_ready && !reset_bufs;
    w_ld_w0    = w_acc && (w_cur_state == S_W0);
    w_ld_w1    = w_acc && (w_cur_state == S_W1);
    w_ld_w2    = w_acc && (w_cur_state == S_W2);
    w_ld_t0    = w_acc && (w_cur_state == S_T0);
    w_ld_t1    = w_acc && (w_cur_state == S_T1);
    w_ld_t2    = w_acc && (w_cur_state == S_T2);
    w_ld_ctr   = w_acc && (w_cur_state == S_CTR);
  end

  // Frame geometry capture and channel/sample position counters
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_first   <= 1'b1;
      r_nsamps  <= '0;
      r_ch_last <= '0;
      r_ch      <= '0;
      r_idx     <= '0;
    end else if (reset_bufs) begin
      r_first   <= 1'b1;
      r_nsamps  <= '0;
      r_ch_last <= '0;
      r_ch      <= '0;
      r_idx     <= '0;
    end else if (w_acc) begin
      if (r_first) begin
        r_first   <= 1'b0;
        r_nsamps  <= nrx_samps;
        r_ch_last <= w_ch_last_live;
      end
      if (w_ld_w2) begin
        if (r_ch == r_ch_last) begin
          r_ch  <= '0;
          r_idx <= r_idx + 16'd1;
        end else begin
          r_ch  <= r_ch + 1'b1;
        end
      end
      if (w_ld_ctr) begin
        r_first <= 1'b1;
        r_ch    <= '0;
        r_idx   <= '0;
      end
    end
  end

  // Hold the low halves of I/Q and the low ticks words until completed
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_w0 <= '0;
      r_w1 <= '0;
      r_t0 <= '0;
      r_t1 <= '0;
    end else if (reset_bufs) begin
      r_w0 <= '0;
      r_w1 <= '0;
      r_t0 <= '0;
      r_t1 <= '0;
    end else begin
      if (w_ld_w0) r_w0 <= s.in_data;
      if (w_ld_w1) r_w1 <= s.in_data;
      if (w_ld_t0) r_t0 <= s.in_data;
      if (w_ld_t1) r_t1 <= s.in_data;
    end
  end

  // Sample output register with valid/ready hold
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_samp_valid <= 1'b0;
      r_samp_ch    <= '0;
      r_samp_idx   <= '0;
      r_samp_i     <= '0;
      r_samp_q     <= '0;
    end else if (reset_bufs) begin
      r_samp_valid <= 1'b0;
      r_samp_ch    <= '0;
      r_samp_idx   <= '0;
      r_samp_i     <= '0;
      r_samp_q     <= '0;
    end else if (w_ld_w2) begin
      r_samp_valid <= 1'b1;
      r_samp_ch    <= r_ch;
      r_samp_idx   <= r_idx;
      r_samp_i     <= {s.in_data[15:8], r_w0};
      r_samp_q     <= {s.in_data[7:0],  r_w1};
    end else if (s.samp_ready) begin
      r_samp_valid <= 1'b0;
    end
  end

  // Timestamp assembly
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_ticks       <= '0;
      r_ticks_valid <= 1'b0;
    end else if (reset_bufs) begin
      r_ticks       <= '0;
      r_ticks_valid <= 1'b0;
    end else begin
      r_ticks_valid <= w_ld_t2;
      if (w_ld_t2)
        r_ticks <= {s.in_data, r_t1, r_t0};
    end
  end

  // Buffer counter continuity; the first counter after a clear only primes
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_buf_ctr       <= '0;
      r_frame_done    <= 1'b0;
      r_seq_err       <= 1'b0;
      r_seq_err_pulse <= 1'b0;
      r_primed        <= 1'b0;
    end else if (reset_bufs) begin
      r_buf_ctr       <= '0;
      r_frame_done    <= 1'b0;
      r_seq_err       <= 1'b0;
      r_seq_err_pulse <= 1'b0;
      r_primed        <= 1'b0;
    end else begin
      r_frame_done    <= w_ld_ctr;
      r_seq_err_pulse <= w_ld_ctr && r_primed && w_ctr_gap;
      if (w_ld_ctr) begin
        r_buf_ctr <= s.in_data;
        r_primed  <= 1'b1;
        if (r_primed && w_ctr_gap)
          r_seq_err <= 1'b1;
      end
    end
  end

  assign s.in_ready    = w_in_ready;
  assign s.samp_valid  = r_samp_valid;
  assign s.samp_ch     = r_samp_ch;
  assign s.samp_idx    = r_samp_idx;
  assign s.samp_i      = r_samp_i;
  assign s.samp_q      = r_samp_q;
  assign ticks         = r_ticks;
  assign ticks_valid   = r_ticks_valid;
  assign buf_ctr       = r_buf_ctr;
  assign frame_done    = r_frame_done;
  assign seq_err       = r_seq_err;
  assign seq_err_pulse = r_seq_err_pulse;

endmodule

// File: tb/tb_rx_audio_frame_unpack.sv
// Randomised bench for rx_audio_frame_unpack against a frame-level model:
// each frame is built as a word list with expected samples, ticks and
// counter outcomes queued up front; a monitor pops them as the DUT emits.
module tb_rx_audio_frame_unpack;

  localparam int NCH_MAX = 8;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        reset_bufs;
  logic [15:0] nrx_samps;
  logic [3:0]  nrx_chans;
  logic [47:0] ticks;
  logic        ticks_valid;
  logic [15:0] buf_ctr;
  logic        frame_done;
  logic        seq_err;
  logic        seq_err_pulse;

  rx_audio_frame_unpack_if #(.NCH_MAX(NCH_MAX)) bus ();

  rx_audio_frame_unpack #(.NCH_MAX(NCH_MAX)) dut (
    .cpu_clk       (cpu_clk),
    .reset         (reset),
    .reset_bufs    (reset_bufs),
    .nrx_samps     (nrx_samps),
    .nrx_chans     (nrx_chans),
    .s             (bus),
    .ticks         (ticks),
    .ticks_valid   (ticks_valid),
    .buf_ctr       (buf_ctr),
    .frame_done    (frame_done),
    .seq_err       (seq_err),
    .seq_err_pulse (seq_err_pulse)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] idx;
    logic [23:0] i;
    logic [23:0] q;
  } samp_t;

  typedef struct {
    logic [15:0] ctr;
    logic        pulse;
    logic        err;
  } frm_t;

  samp_t       q_samp[$];
  frm_t        q_frm[$];
  logic [47:0] q_tick[$];

  // Model of counter continuity
  logic        m_primed = 1'b0;
  logic        m_err    = 1'b0;
  logic [15:0] m_prev   = '0;

  logic rdy_hold = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: random unless held low
  initial begin
    bus.samp_ready = 1'b0;
    forever begin
      @(posedge cpu_clk);
      #2;
      bus.samp_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: everything sampled mid-cycle, away from the active edge
  initial begin
    samp_t es;
    frm_t  ef;
    forever begin
      @(negedge cpu_clk);
      if (bus.samp_valid && bus.samp_ready) begin
        if (q_samp.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          es = q_samp.pop_front();
          chk("samp_ch",  64'(bus.samp_ch),  64'(es.ch));
          chk("samp_idx", 64'(bus.samp_idx), 64'(es.idx));
          chk("samp_i",   64'(bus.samp_i),   64'(es.i));
          chk("samp_q",   64'(bus.samp_q),   64'(es.q));
        end
      end
      if (ticks_valid) begin
        if (q_tick.size() == 0) chk("unexpected_ticks", 1, 0);
        else chk("ticks", 64'(ticks), 64'(q_tick.pop_front()));
      end
      if (frame_done) begin
        if (q_frm.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          ef = q_frm.pop_front();
          chk("buf_ctr",       64'(buf_ctr),       64'(ef.ctr));
          chk("seq_err_pulse", 64'(seq_err_pulse), 64'(ef.pulse));
          chk("seq_err",       64'(seq_err),       64'(ef.err));
        end
      end else if (seq_err_pulse) begin
        chk("stray_err_pulse", 1, 0);
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    n = 0;
    forever begin
      @(negedge cpu_clk);
      acc = bus.in_ready;
      @(posedge cpu_clk);
      #1;
      if (acc) break;
      n++;
      if (n > 2000) begin
        chk("word_timeout", 1, 0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int ns, input int nc, input logic [47:0] tk,
                            input logic [15:0] ctr, input bit fixed);
    logic [15:0] words[$];
    samp_t       es;
    frm_t        ef;
    int          neff;
    neff = (nc == 0) ? 1 : ((nc > NCH_MAX) ? NCH_MAX : nc);
    for (int si = 0; si < ns; si++) begin
      for (int c = 0; c < neff; c++) begin
        es.ch  = 3'(c);
        es.idx = 16'(si);
        es.i   = fixed ? 24'h123456 : 24'($urandom);
        es.q   = fixed ? 24'hFEDCBA : 24'($urandom);
        q_samp.push_back(es);
        words.push_back(es.i[15:0]);
        words.push_back(es.q[15:0]);
        words.push_back({es.i[23:16], es.q[23:16]});
      end
    end
    words.push_back(tk[15:0]);
    words.push_back(tk[31:16]);
    words.push_back(tk[47:32]);
    words.push_back(ctr);
    q_tick.push_back(tk);
    ef.ctr   = ctr;
    ef.pulse = m_primed && (ctr != m_prev + 16'd1);
    if (ef.pulse) m_err = 1'b1;
    ef.err   = m_err;
    m_primed = 1'b1;
    m_prev   = ctr;
    q_frm.push_back(ef);

    nrx_samps = 16'(ns);
    nrx_chans = 4'(nc);
    for (int k = 0; k < words.size(); k++) begin
      send_word(words[k]);
      if (k == 0) begin
        // configuration changes after the frame start must not matter
        nrx_samps = 16'($urandom_range(0, 5));
        nrx_chans = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge cpu_clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_samp.size() + q_frm.size() + q_tick.size()) != 0 && n < 500) begin
      @(posedge cpu_clk);
      n++;
    end
    chk("drain", 64'(q_samp.size() + q_frm.size() + q_tick.size()), 0);
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_resync();
    reset_bufs   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'($urandom);
    @(posedge cpu_clk);
    #1;
    reset_bufs   = 1'b0;
    bus.in_valid = 1'b0;
    m_primed = 1'b0;
    m_err    = 1'b0;
    m_prev   = '0;
    @(negedge cpu_clk);
    chk("rs_seq_err",    64'(seq_err),        0);
    chk("rs_buf_ctr",    64'(buf_ctr),        0);
    chk("rs_ticks",      64'(ticks),          0);
    chk("rs_samp_valid", 64'(bus.samp_valid), 0);
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic [23:0] si_hold;
    logic [23:0] sq_hold;
    logic [15:0] c;
    int          n;

    reset        = 1'b1;
    reset_bufs   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    nrx_samps    = 16'd1;
    nrx_chans    = 4'd1;
    repeat (3) @(posedge cpu_clk);
    #1;
    reset = 1'b0;

    @(negedge cpu_clk);
    chk("rst_samp_valid", 64'(bus.samp_valid), 0);
    chk("rst_in_ready",   64'(bus.in_ready),   1);
    chk("rst_ticks",      64'(ticks),          0);
    chk("rst_buf_ctr",    64'(buf_ctr),        0);
    chk("rst_seq_err",    64'(seq_err),        0);
    chk("rst_frame_done", 64'(frame_done),     0);
    @(posedge cpu_clk);
    #1;

    // Directed single frame
    send_frame(2, 1, 48'h3333_2222_1111, 16'd5, 1'b1);
    drain();
    chk("f1_buf_ctr", 64'(buf_ctr), 5);
    chk("f1_ticks",   64'(ticks),   48'h3333_2222_1111);

    // Multichannel, then continuity 6, 8 (gap), 9
    send_frame(2, 3, 48'($urandom), 16'd6, 1'b0);
    send_frame(1, 2, 48'($urandom), 16'd8, 1'b0);
    send_frame(1, 1, 48'($urandom), 16'd9, 1'b0);
    drain();
    chk("err_sticky", 64'(seq_err), 1);
    do_resync();

    // Backpressure: hold samp_ready low once the first sample is out
    rdy_hold       = 1'b1;
    bus.samp_ready = 1'b0;
    fork
      send_frame(2, 2, 48'($urandom), 16'h0100, 1'b0);
      begin
        n = 0;
        while (!bus.samp_valid && n < 200) begin
          @(negedge cpu_clk);
          n++;
        end
        chk("bp_valid", 64'(bus.samp_valid), 1);
        si_hold = bus.samp_i;
        sq_hold = bus.samp_q;
        repeat (6) begin
          @(negedge cpu_clk);
          chk("bp_in_ready", 64'(bus.in_ready), 0);
          chk("bp_hold_i",   64'(bus.samp_i),   64'(si_hold));
          chk("bp_hold_q",   64'(bus.samp_q),   64'(sq_hold));
        end
        rdy_hold = 1'b0;
      end
    join
    drain();

    // Boundaries: no samples, nrx_chans=0, counter wrap
    send_frame(0, 1, 48'($urandom), 16'h0101, 1'b0);
    send_frame(2, 0, 48'($urandom), 16'hFFFF, 1'b0);
    send_frame(1, 8, 48'($urandom), 16'h0000, 1'b0);
    drain();

    // Random frames with occasional counter jumps
    c = m_prev;
    for (int f = 0; f < 20; f++) begin
      c = ($urandom_range(0, 4) == 0) ? 16'($urandom) : c + 16'd1;
      send_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                 48'({$urandom, $urandom}), c, 1'b0);
    end
    drain();

    // Mid-frame resync after W1; next frame starts fresh and only primes
    send_frame(1, 1, 48'h0A0B_0C0D_0E0F, m_prev + 16'd7, 1'b0);
    drain();
    nrx_samps = 16'd1;
    nrx_chans = 4'd1;
    send_word(16'hAAAA);
    send_word(16'hBBBB);
    do_resync();
    send_frame(2, 2, 48'($urandom), 16'h4321, 1'b0);
    send_frame(1, 1, 48'($urandom), 16'h4322, 1'b0);
    drain();
    chk("end_seq_err", 64'(seq_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

endmodule
